qar_writeback: RTL and testbench
================================

// Module: qar_writeback
// PURPOSE
//   Writeback stage feeding the single write port of the regfile (we/waddr/wdata).
//   Merges single-cycle ALU results with long-latency LSU load results. LSU results
//   are held in a small in-order queue. The stage arbitrates one register write per
//   cycle, discards x0 writes, squashes stale queued loads (WAW) and exports a
//   pending-rd mask for hazard detection.
// PARAMETERS
//   XLEN    32  data width of results and regfile write data
//   AW      5   register address width (2**AW architectural registers)
//   QDEPTH  2   LSU result queue depth, power of two, >=2
// PORTS
//   clk        in   1         rising-edge clock
//   rst_n      in   1         asynchronous active-low reset
//   alu_valid  in   1         ALU result present this cycle; never backpressured
//   alu_rd     in   AW        ALU destination register
//   alu_data   in   XLEN      ALU result
//   lsu_valid  in   1         LSU result offered
//   lsu_ready  out  1         queue can accept; transfer = lsu_valid & lsu_ready
//   lsu_rd     in   AW        LSU destination register
//   lsu_data   in   XLEN      LSU result
//   rf_we      out  1         regfile write enable (registered)
//   rf_waddr   out  AW        regfile write address (registered)
//   rf_wdata   out  XLEN      regfile write data (registered)
//   pend_mask  out  2**AW     bit r=1: a live queued LSU entry targets register r
//   stall_req  out  1         queue full; core must hold issue of new loads
// BEHAVIOUR
//   - Reset (async, immediate): queue empty, rf_we=0, rf_waddr=0, rf_wdata=0,
//     pend_mask=0, stall_req=0, lsu_ready=1. Any in-flight write is dropped.
//   - Latency: a selected result appears on rf_* exactly 1 cycle after selection.
//     rf_we is high for one cycle per write. rf_* hold their last value when rf_we=0.
//   - Arbitration each cycle:
//     (1) alu_valid & alu_rd!=0 wins the port.
//     (2) otherwise, pop the queue head. A live head is written. A dead head is
//         popped with rf_we=0 next cycle.
//   - x0: ALU results with rd=0 are dropped and do not take the port; the queue may
//     pop that cycle. LSU results with rd=0 are accepted (handshake completes) but
//     not enqueued.
//   - Enqueue: on transfer with lsu_rd!=0, the entry is pushed live at the tail.
//     lsu_ready = !full, computed from the occupancy count only. A pop in the same
//     cycle does not free a slot for a push that cycle.
//   - Simultaneous push and pop: allowed when not full; count is unchanged.
//   - Ordering: a queued entry, or one pushed in the same cycle, is older than the
//     concurrent and all later ALU results.
//   - WAW squash: when the ALU wins with rd=R, every live queue entry with rd=R is
//     marked dead. This includes an entry pushed that same cycle.
//   - pend_mask: OR of one-hot(rd) over live entries, registered (reflects queue
//     state after the clock edge). The output-register write is not included.
//   - stall_req = full (registered count == QDEPTH).
//   - Pointers are log2(QDEPTH) bits and wrap naturally. Count is log2(QDEPTH)+1 bits.
//   - Overflow is impossible by handshake. Pop on empty is a no-op.
// TESTING
//   1 ALU: alu_valid=1 rd=5 data=123 for 1 cycle -> next cycle rf_we=1 waddr=5
//     wdata=123, then rf_we=0.
//   2 x0: alu rd=0 data=999 -> rf_we stays 0. LSU rd=0 -> lsu_ready=1, handshake
//     completes, queue stays empty, no write.
//   3 LSU: rd=7 data=0xAA, no ALU -> pend_mask[7]=1 for 1 cycle, then rf_we=1
//     waddr=7 wdata=0xAA.
//   4 Full/drain: ALU writes rd=1..3 on 3 consecutive cycles. During these, LSU
//     pushes rd=8 (0x11) and rd=9 (0x22) -> lsu_ready=0, stall_req=1. After the
//     ALU stops, writes 8 then 9 on consecutive cycles; lsu_ready returns to 1.
//   5 WAW: LSU rd=9 queued behind busy ALU, then ALU rd=9 data=0x55 -> single write
//     9=0x55. pend_mask[9] clears. The queued load pops dead with no later write to 9.
//   6 Reset mid-drain: 2 entries queued, rst_n low for half a cycle -> rf_we=0 and
//     pend_mask=0 immediately. After release no writes occur and lsu_ready=1.

Source files
------------

// File: rtl/qar_writeback.sv
// Writeback stage for the single regfile write port: ALU results take priority over
// an in-order LSU result queue; x0 writes are dropped and stale queued loads are squashed.
module qar_writeback #(
   parameter int XLEN   = 32,
   parameter int AW     = 5,
   parameter int QDEPTH = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   input  logic [AW-1:0]     alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              lsu_valid,
   output logic              lsu_ready,
   input  logic [AW-1:0]     lsu_rd,
   input  logic [XLEN-1:0]   lsu_data,
   output logic              rf_we,
   output logic [AW-1:0]     rf_waddr,
   output logic [XLEN-1:0]   rf_wdata,
   output logic [2**AW-1:0]  pend_mask,
   output logic              stall_req
);

   localparam int PW = $clog2(QDEPTH);
   localparam int CW = PW + 1;

   logic [AW-1:0]     rd_q   [QDEPTH];
   logic [XLEN-1:0]   data_q [QDEPTH];
   logic [QDEPTH-1:0] live_q, live_n;
   logic [PW-1:0]     head_q, tail_q;
   logic [CW-1:0]     count_q;
   logic [2**AW-1:0]  pend_n;
   logic [AW-1:0]     idx;
   logic              full, alu_win, push, pop, push_live, head_live;

   assign full      = (count_q == CW'(QDEPTH));
   assign lsu_ready = !full;
   assign stall_req = full;
   assign alu_win   = alu_valid && (alu_rd != '0);
   assign push      = lsu_valid && !full && (lsu_rd != '0);
   assign pop       = !alu_win && (count_q != '0);
   assign head_live = live_q[head_q];
   // A load pushed in the same cycle is older than the winning ALU result, so it dies too.
   assign push_live = !(alu_win && (lsu_rd == alu_rd));

   always_comb begin
      live_n = live_q;
      pend_n = '0;
      idx    = '0;
      if (pop)
         live_n[head_q] = 1'b0;
      if (alu_win) begin
         for (int i = 0; i < QDEPTH; i++)
            if (live_q[i] && (rd_q[i] == alu_rd))
               live_n[i] = 1'b0;
      end
      if (push)
         live_n[tail_q] = push_live;
      for (int i = 0; i < QDEPTH; i++) begin
         idx = (push && (PW'(i) == tail_q)) ? lsu_rd : rd_q[i];
         if (live_n[i])
            pend_n[idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
         live_q    <= '0;
         pend_mask <= '0;
      end else begin
         live_q    <= live_n;
         pend_mask <= pend_n;
         if (pop)
            head_q <= head_q + 1'b1;
         if (push)
            tail_q <= tail_q + 1'b1;
         case ({push, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         rd_q[tail_q]   <= lsu_rd;
         data_q[tail_q] <= lsu_data;
      end
   end

   // Output register stage: one write per cycle, held when idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we    <= 1'b0;
         rf_waddr <= '0;
         rf_wdata <= '0;
      end else begin
         rf_we <= alu_win || (pop && head_live);
         if (alu_win) begin
            rf_waddr <= alu_rd;
            rf_wdata <= alu_data;
         end else if (pop && head_live) begin
            rf_waddr <= rd_q[head_q];
            rf_wdata <= data_q[head_q];
         end
      end
   end

endmodule

// File: tb/tb_qar_writeback.sv
// Directed bench for qar_writeback: queue-based reference model checked every cycle,
// plus literal expectations for each scenario.
module tb_qar_writeback;

   localparam int XLEN = 32;
   localparam int AW = 5;
   localparam int QDEPTH = 2;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            alu_valid = 1'b0;
   logic [AW-1:0]   alu_rd = '0;
   logic [XLEN-1:0] alu_data = '0;
   logic            lsu_valid = 1'b0;
   logic            lsu_ready;
   logic [AW-1:0]   lsu_rd = '0;
   logic [XLEN-1:0] lsu_data = '0;
   logic            rf_we;
   logic [AW-1:0]   rf_waddr;
   logic [XLEN-1:0] rf_wdata;
   logic [31:0]     pend_mask;
   logic            stall_req;

   int nvec = 0;
   int nerr = 0;

   qar_writeback #(.XLEN(XLEN), .AW(AW), .QDEPTH(QDEPTH)) dut (
      .clk(clk), .rst_n(rst_n),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .pend_mask(pend_mask), .stall_req(stall_req)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", nm, $time, act, exp);
      end
   endtask

   // Reference model: a plain FIFO of pending loads with a live flag per entry.
   typedef struct {
      logic [AW-1:0]   rd;
      logic [XLEN-1:0] data;
      bit              live;
   } ent_t;

   ent_t            q[$];
   logic            m_we = 1'b0;
   logic [AW-1:0]   m_waddr = '0;
   logic [XLEN-1:0] m_wdata = '0;

   function automatic logic [31:0] m_pend();
      logic [31:0] m = '0;
      foreach (q[i]) if (q[i].live) m[q[i].rd] = 1'b1;
      return m;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q.delete();
         m_we = 1'b0;
         m_waddr = '0;
         m_wdata = '0;
      end else begin
         bit   win, psh;
         ent_t e;
         win = alu_valid && alu_rd != 0;
         psh = lsu_valid && (q.size() < QDEPTH) && lsu_rd != 0;
         m_we = 1'b0;
         if (win) begin
            m_we = 1'b1;
            m_waddr = alu_rd;
            m_wdata = alu_data;
            foreach (q[i]) if (q[i].rd == alu_rd) q[i].live = 1'b0;
         end else if (q.size() > 0) begin
            e = q.pop_front();
            if (e.live) begin
               m_we = 1'b1;
               m_waddr = e.rd;
               m_wdata = e.data;
            end
         end
         if (psh) begin
            e.rd = lsu_rd;
            e.data = lsu_data;
            e.live = !(win && lsu_rd == alu_rd);
            q.push_back(e);
         end
      end
   end

   always @(posedge clk) begin
      #1;
      chk("m_we", {31'b0, rf_we}, {31'b0, m_we});
      chk("m_waddr", 32'(rf_waddr), 32'(m_waddr));
      chk("m_wdata", rf_wdata, m_wdata);
      chk("m_pend", pend_mask, m_pend());
      chk("m_ready", {31'b0, lsu_ready}, {31'b0, q.size() < QDEPTH});
      chk("m_stall", {31'b0, stall_req}, {31'b0, q.size() == QDEPTH});
   end

   task automatic cyc(input logic av, input logic [AW-1:0] ard, input logic [XLEN-1:0] ad,
                      input logic lv, input logic [AW-1:0] lrd, input logic [XLEN-1:0] ld);
      alu_valid = av; alu_rd = ard; alu_data = ad;
      lsu_valid = lv; lsu_rd = lrd; lsu_data = ld;
      @(negedge clk);
   endtask

   task automatic idle();
      cyc(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   initial begin
      @(negedge clk);
      chk("rst_we", {31'b0, rf_we}, 32'd0);
      chk("rst_ready", {31'b0, lsu_ready}, 32'd1);
      chk("rst_pend", pend_mask, 32'd0);
      rst_n = 1'b1;
      idle();

      // 1: single ALU write
      cyc(1'b1, 5'd5, 32'd123, 1'b0, '0, '0);
      chk("t1_we", {31'b0, rf_we}, 32'd1);
      chk("t1_addr", 32'(rf_waddr), 32'd5);
      chk("t1_data", rf_wdata, 32'd123);
      idle();
      chk("t1_we_off", {31'b0, rf_we}, 32'd0);
      chk("t1_hold", rf_wdata, 32'd123);

      // 2: x0 from both sources
      chk("t2_ready", {31'b0, lsu_ready}, 32'd1);
      cyc(1'b1, 5'd0, 32'd999, 1'b1, 5'd0, 32'h77);
      chk("t2_we", {31'b0, rf_we}, 32'd0);
      chk("t2_pend", pend_mask, 32'd0);
      idle();
      chk("t2_we2", {31'b0, rf_we}, 32'd0);
      chk("t2_data", rf_wdata, 32'd123);

      // 3: LSU write through the queue
      cyc(1'b0, '0, '0, 1'b1, 5'd7, 32'hAA);
      chk("t3_pend", pend_mask, 32'h80);
      chk("t3_we0", {31'b0, rf_we}, 32'd0);
      idle();
      chk("t3_we", {31'b0, rf_we}, 32'd1);
      chk("t3_addr", 32'(rf_waddr), 32'd7);
      chk("t3_data", rf_wdata, 32'hAA);
      chk("t3_pend0", pend_mask, 32'd0);

      // 4: fill while ALU is busy, then drain
      cyc(1'b1, 5'd1, 32'd1, 1'b1, 5'd8, 32'h11);
      chk("t4_a1", 32'(rf_waddr), 32'd1);
      cyc(1'b1, 5'd2, 32'd2, 1'b1, 5'd9, 32'h22);
      chk("t4_full_rdy", {31'b0, lsu_ready}, 32'd0);
      chk("t4_stall", {31'b0, stall_req}, 32'd1);
      chk("t4_pend", pend_mask, 32'h300);
      cyc(1'b1, 5'd3, 32'd3, 1'b0, '0, '0);
      chk("t4_a3", 32'(rf_waddr), 32'd3);
      idle();
      chk("t4_w8", 32'(rf_waddr), 32'd8);
      chk("t4_d8", rf_wdata, 32'h11);
      chk("t4_rdy", {31'b0, lsu_ready}, 32'd1);
      idle();
      chk("t4_w9", 32'(rf_waddr), 32'd9);
      chk("t4_d9", rf_wdata, 32'h22);
      chk("t4_we9", {31'b0, rf_we}, 32'd1);
      idle();

      // 5: WAW squash of a queued load
      cyc(1'b1, 5'd4, 32'h44, 1'b1, 5'd9, 32'h99);
      chk("t5_pend", pend_mask, 32'h200);
      cyc(1'b1, 5'd9, 32'h55, 1'b0, '0, '0);
      chk("t5_addr", 32'(rf_waddr), 32'd9);
      chk("t5_data", rf_wdata, 32'h55);
      chk("t5_pend0", pend_mask, 32'd0);
      idle();
      chk("t5_dead", {31'b0, rf_we}, 32'd0);
      chk("t5_hold", rf_wdata, 32'h55);
      idle();
      chk("t5_none", {31'b0, rf_we}, 32'd0);

      // 6: asynchronous reset with two queued loads
      cyc(1'b1, 5'd1, 32'd10, 1'b1, 5'd10, 32'hA0);
      cyc(1'b1, 5'd2, 32'd20, 1'b1, 5'd11, 32'hB0);
      chk("t6_stall", {31'b0, stall_req}, 32'd1);
      alu_valid = 1'b0; lsu_valid = 1'b0;
      rst_n = 1'b0;
      #1;
      chk("t6_we", {31'b0, rf_we}, 32'd0);
      chk("t6_pend", pend_mask, 32'd0);
      chk("t6_addr", 32'(rf_waddr), 32'd0);
      chk("t6_data", rf_wdata, 32'd0);
      chk("t6_rdy", {31'b0, lsu_ready}, 32'd1);
      @(posedge clk);
      #1 rst_n = 1'b1;
      idle();
      idle();
      chk("t6_nowr", {31'b0, rf_we}, 32'd0);
      idle();
      chk("t6_rdy2", {31'b0, lsu_ready}, 32'd1);
      chk("t6_stall0", {31'b0, stall_req}, 32'd0);

      @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
